// File: rtl/vga_frame_capture.sv
// -----------------------------------------------------------------------------
// vga_frame_capture
// Captures one complete frame of 8-bit grayscale pixels from a VGA-timed pixel
// stream. Pixels are packed four to a 32-bit little-endian word and written to a
// frame-buffer memory through a small write FIFO and a valid/ready write port.
//
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   pix_en           one-cycle strobe per pixel period (qualifies the inputs below)
//   hsync_in         horizontal sync, active low
//   vsync_in         vertical sync, active low
//   visible_in       pixel lies in the active area
//   pixel_in[7:0]    grayscale pixel value
//   arm              pulse: capture the next complete frame (IDLE/DONE only)
//   mem_we           write request valid (FIFO not empty)
//   mem_addr         word address of the FIFO head
//   mem_wdata        packed pixels of the FIFO head
//   mem_ready        memory accepts the head word when mem_we && mem_ready
//   busy             capture in progress (WAIT_VS, CAPTURE or DRAIN)
//   frame_done       frame fully written, held until the next arm
//   overflow         sticky: a word was dropped because the FIFO was full
//   line_err         sticky: a line ended with a visible count other than H_ACTIVE
//   frame_err        sticky: vsync arrived before the frame was complete
// -----------------------------------------------------------------------------
module vga_frame_capture #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              visible_in,
    input  logic [7:0]        pixel_in,
    input  logic              arm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic              line_err,
    output logic              frame_err
);

    localparam int unsigned TOTAL_WORDS = H_ACTIVE * V_ACTIVE / 4;
    // x_cnt saturates at H_ACTIVE+1 so over-long lines still read as bad
    localparam int unsigned X_W         = $clog2(H_ACTIVE + 2);
    localparam int unsigned PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W       = PTR_W + 1;
    localparam int unsigned ENTRY_W     = ADDR_W + 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_VS = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t              state_q;
    logic                hs_prev_q;
    logic                vs_prev_q;
    logic [X_W-1:0]      x_cnt_q;
    logic [1:0]          pack_idx_q;
    // Only pixels 0..2 of a group are stored; pixel 3 goes straight into the word
    logic [23:0]         pack_q;
    logic [ADDR_W-1:0]   word_cnt_q;
    logic                overflow_q;
    logic                line_err_q;
    logic                frame_err_q;

    logic [ENTRY_W-1:0]  fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;

    logic                hs_fall;
    logic                vs_fall;
    logic                vs_rise;
    logic                pix_take;
    logic                push;
    logic                pop;
    logic                full;
    logic                push_ok;
    logic                last_word;
    logic [31:0]         push_word;

    // Sync edges compare the current sample with the previous pix_en sample
    assign hs_fall   = pix_en & hs_prev_q & ~hsync_in;
    assign vs_fall   = pix_en & vs_prev_q & ~vsync_in;
    assign vs_rise   = pix_en & ~vs_prev_q & vsync_in;

    assign pix_take  = (state_q == ST_CAPTURE) & pix_en & visible_in;
    assign push      = pix_take & (pack_idx_q == 2'd3);
    assign pop       = (count_q != '0) & mem_ready;
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    // A same-cycle pop frees the slot, so a push into a full FIFO is still accepted
    assign push_ok   = push & (~full | pop);
    assign last_word = (word_cnt_q == ADDR_W'(TOTAL_WORDS - 1));
    assign push_word = {pixel_in, pack_q};

    // Write port presents the FIFO head directly
    assign mem_we                = (count_q != '0);
    assign {mem_addr, mem_wdata} = fifo_mem_q[rd_ptr_q];

    assign busy       = (state_q == ST_WAIT_VS) | (state_q == ST_CAPTURE) | (state_q == ST_DRAIN);
    assign frame_done = (state_q == ST_DONE);
    assign overflow   = overflow_q;
    assign line_err   = line_err_q;
    assign frame_err  = frame_err_q;

    // FIFO storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q] <= {word_cnt_q, push_word};
        end
    end

    // Capture FSM, sync sampling, packing and FIFO bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hs_prev_q   <= 1'b1;
            vs_prev_q   <= 1'b1;
            x_cnt_q     <= '0;
            pack_idx_q  <= '0;
            pack_q      <= '0;
            word_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            if (pix_en) begin
                hs_prev_q <= hsync_in;
                vs_prev_q <= vsync_in;
            end

            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop);

            if (push & full & ~pop) begin
                overflow_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_q     <= ST_WAIT_VS;
                        overflow_q  <= 1'b0;
                        line_err_q  <= 1'b0;
                        frame_err_q <= 1'b0;
                    end
                end

                ST_WAIT_VS: begin
                    if (vs_rise) begin
                        state_q    <= ST_CAPTURE;
                        x_cnt_q    <= '0;
                        pack_idx_q <= '0;
                        word_cnt_q <= '0;
                    end
                end

                ST_CAPTURE: begin
                    if (pix_take) begin
                        case (pack_idx_q)
                            2'd0:    pack_q[7:0]   <= pixel_in;
                            2'd1:    pack_q[15:8]  <= pixel_in;
                            2'd2:    pack_q[23:16] <= pixel_in;
                            default: pack_q        <= pack_q;
                        endcase
                        pack_idx_q <= pack_idx_q + 2'd1;
                        if (x_cnt_q <= X_W'(H_ACTIVE)) begin
                            x_cnt_q <= x_cnt_q + X_W'(1);
                        end
                        // Dropped words still consume an address
                        if (push) begin
                            word_cnt_q <= word_cnt_q + ADDR_W'(1);
                        end
                    end

                    // End of line: a partial group is discarded
                    if (hs_fall) begin
                        if ((x_cnt_q != '0) && (x_cnt_q != X_W'(H_ACTIVE))) begin
                            line_err_q <= 1'b1;
                        end
                        x_cnt_q    <= '0;
                        pack_idx_q <= '0;
                    end

                    if (push & last_word) begin
                        state_q <= ST_DRAIN;
                    end else if (vs_fall) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    if (count_q == '0) begin
                        state_q <= ST_DONE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
